// File: rtl/am_ch_fader.sv
// Per-channel click-free gain fader: ramps each channel's linear gain toward its target once per
// tick, and mutes every channel at once on hard_mute.
module am_ch_fader #(
  parameter int unsigned NUM_CH   = 12,
  parameter int unsigned GAIN_W   = 10,
  parameter int unsigned STEP     = 4,
  parameter int unsigned TICK_DIV = 1250
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     master_enable,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     hard_mute,
  output logic [NUM_CH*GAIN_W-1:0] gain_out,
  output logic [NUM_CH-1:0]        ch_on,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic                     all_off
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [GAIN_W:0] GMax   = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [GAIN_W:0] StepW  = (GAIN_W + 1)'(STEP);

  typedef enum logic [1:0] {StOff, StUp, StOn, StDown} state_e;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tick;
  logic [NUM_CH-1:0] target;
  logic [GAIN_W-1:0] gain_q  [NUM_CH];
  logic [GAIN_W-1:0] gain_d  [NUM_CH];
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];

  assign tick   = (cnt_q == CntMax);
  assign target = ch_enable & {NUM_CH{master_enable & ~hard_mute}};

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin : g_next
      logic [GAIN_W:0] up;
      logic [GAIN_W:0] dn;
      logic            go_up;
      logic            go_dn;
      gain_d[i]  = gain_q[i];
      state_d[i] = state_q[i];
      // Extra bit catches overflow on the way up and borrow on the way down.
      up = {1'b0, gain_q[i]} + StepW;
      if (up > GMax) up = GMax;
      dn = {1'b0, gain_q[i]} - StepW;
      if (dn[GAIN_W]) dn = '0;
      go_up = 1'b0;
      go_dn = 1'b0;
      unique case (state_q[i])
        StOff:   go_up = target[i];
        StOn:    go_dn = ~target[i];
        default: begin
          go_up = target[i];
          go_dn = ~target[i];
        end
      endcase
      if (hard_mute) begin
        gain_d[i]  = '0;
        state_d[i] = StOff;
      end else if (tick && go_up) begin
        gain_d[i]  = up[GAIN_W-1:0];
        state_d[i] = (up == GMax) ? StOn : StUp;
      end else if (tick && go_dn) begin
        gain_d[i]  = dn[GAIN_W-1:0];
        state_d[i] = (dn == '0) ? StOff : StDown;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        gain_q[i]  <= '0;
        state_q[i] <= StOff;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        gain_q[i]  <= gain_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  // Outputs decode flopped state only, so they all move on the same edge as the gains.
  always_comb begin
    all_off = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      gain_out[i*GAIN_W +: GAIN_W] = gain_q[i];
      ch_on[i]   = (state_q[i] == StOn);
      ch_busy[i] = (state_q[i] == StUp) || (state_q[i] == StDown);
      if (state_q[i] != StOff) all_off = 1'b0;
    end
  end

endmodule

// File: tb/tb_am_ch_fader.sv
// Bench for am_ch_fader: directed ramp/mute/reset scenarios plus random input traffic, checked
// every clock against a gain-level reference model for two step sizes.
module tb_am_ch_fader;

  localparam int NCH  = 12;
  localparam int GW   = 10;
  localparam int TDIV = 4;
  localparam int GMAX = 1023;
  localparam int STEP_A = 4;
  localparam int STEP_B = 1000;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             master_enable = 1'b0;
  logic [NCH-1:0]   ch_enable = '0;
  logic             hard_mute = 1'b0;
  logic [NCH*GW-1:0] ga, gb;
  logic [NCH-1:0]   on_a, busy_a, on_b, busy_b;
  logic             off_a, off_b;

  am_ch_fader #(.NUM_CH(NCH), .GAIN_W(GW), .STEP(STEP_A), .TICK_DIV(TDIV)) u_dut_a (
    .clk(clk), .rstn(rstn), .master_enable(master_enable), .ch_enable(ch_enable),
    .hard_mute(hard_mute), .gain_out(ga), .ch_on(on_a), .ch_busy(busy_a), .all_off(off_a)
  );

  am_ch_fader #(.NUM_CH(NCH), .GAIN_W(GW), .STEP(STEP_B), .TICK_DIV(TDIV)) u_dut_b (
    .clk(clk), .rstn(rstn), .master_enable(master_enable), .ch_enable(ch_enable),
    .hard_mute(hard_mute), .gain_out(gb), .ch_on(on_b), .ch_busy(busy_b), .all_off(off_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int ticks  = 0;
  int ga_m [NCH];
  int gb_m [NCH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] g_of(input logic [NCH*GW-1:0] v, input int i);
    return v[i*GW +: GW];
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > GMAX) return GMAX;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      ga_m[i] = 0;
      gb_m[i] = 0;
    end
  endtask

  // One clock edge of the reference: gains move one step toward target on every TDIV-th edge.
  task automatic model_edge();
    bit tk;
    tk = (m_cnt == TDIV - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    if (tk) ticks++;
    for (int i = 0; i < NCH; i++) begin
      if (hard_mute) begin
        ga_m[i] = 0;
        gb_m[i] = 0;
      end else if (tk) begin
        if (master_enable && ch_enable[i]) begin
          ga_m[i] = clamp(ga_m[i] + STEP_A);
          gb_m[i] = clamp(gb_m[i] + STEP_B);
        end else begin
          ga_m[i] = clamp(ga_m[i] - STEP_A);
          gb_m[i] = clamp(gb_m[i] - STEP_B);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NCH*GW-1:0] ega, egb;
    logic [NCH-1:0]    eon_a, ebusy_a, eon_b, ebusy_b;
    logic              eoff_a, eoff_b;
    eoff_a = 1'b1;
    eoff_b = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ega[i*GW +: GW] = GW'(ga_m[i]);
      egb[i*GW +: GW] = GW'(gb_m[i]);
      eon_a[i]   = (ga_m[i] == GMAX);
      eon_b[i]   = (gb_m[i] == GMAX);
      ebusy_a[i] = (ga_m[i] > 0) && (ga_m[i] < GMAX);
      ebusy_b[i] = (gb_m[i] > 0) && (gb_m[i] < GMAX);
      if (ga_m[i] != 0) eoff_a = 1'b0;
      if (gb_m[i] != 0) eoff_b = 1'b0;
    end
    check($sformatf("gain_a t=%0t", $time), 128'(ga), 128'(ega));
    check($sformatf("on_a t=%0t", $time), 128'(on_a), 128'(eon_a));
    check($sformatf("busy_a t=%0t", $time), 128'(busy_a), 128'(ebusy_a));
    check($sformatf("off_a t=%0t", $time), 128'(off_a), 128'(eoff_a));
    check($sformatf("gain_b t=%0t", $time), 128'(gb), 128'(egb));
    check($sformatf("on_b t=%0t", $time), 128'(on_b), 128'(eon_b));
    check($sformatf("busy_b t=%0t", $time), 128'(busy_b), 128'(ebusy_b));
    check($sformatf("off_b t=%0t", $time), 128'(off_b), 128'(eoff_b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_ticks(input int n);
    int t0;
    t0 = ticks;
    while (ticks < t0 + n) cyc();
  endtask

  task automatic async_reset(input string tag);
    rstn = 1'b0;
    #1;
    check({tag, " rst gain_a"}, 128'(ga), 128'(0));
    check({tag, " rst gain_b"}, 128'(gb), 128'(0));
    check({tag, " rst off_a"}, 128'(off_a), 128'(1));
    check({tag, " rst busy_a"}, 128'(busy_a), 128'(0));
    check({tag, " rst on_a"}, 128'(on_a), 128'(0));
    model_reset();
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("por gain_a", 128'(ga), 128'(0));
    check("por off_a", 128'(off_a), 128'(1));
    check("por busy_a", 128'(busy_a), 128'(0));
    #11;
    rstn = 1'b1;

    // Idle after reset.
    repeat (100) cyc();

    // CH1 full ramp up.
    master_enable = 1'b1;
    ch_enable     = 12'h001;
    run_ticks(255);
    check("ramp 255 ticks", 128'(g_of(ga, 0)), 128'(1020));
    check("ramp 255 on", 128'(on_a[0]), 128'(0));
    run_ticks(1);
    check("ramp 256 ticks", 128'(g_of(ga, 0)), 128'(1023));
    check("ramp 256 on", 128'(on_a[0]), 128'(1));

    // Reversal mid-ramp at 400.
    ch_enable = '0;
    run_ticks(256);
    ch_enable = 12'h001;
    run_ticks(100);
    check("rev at 400", 128'(g_of(ga, 0)), 128'(400));
    ch_enable = '0;
    run_ticks(1);
    check("rev first down", 128'(g_of(ga, 0)), 128'(396));
    check("rev busy", 128'(busy_a[0]), 128'(1));
    run_ticks(99);
    check("rev reaches 0", 128'(g_of(ga, 0)), 128'(0));
    check("rev not busy", 128'(busy_a[0]), 128'(0));

    // All channels on, then master off together.
    ch_enable = 12'hfff;
    run_ticks(256);
    check("all on", 128'(on_a), 128'(12'hfff));
    master_enable = 1'b0;
    run_ticks(255);
    check("all 255 down", 128'(off_a), 128'(0));
    check("all 255 ch12", 128'(g_of(ga, 11)), 128'(3));
    run_ticks(1);
    check("all off", 128'(off_a), 128'(1));

    // hard_mute pulse off-tick with CH3 at 512.
    master_enable = 1'b1;
    ch_enable     = 12'h004;
    run_ticks(128);
    check("ch3 at 512", 128'(g_of(ga, 2)), 128'(512));
    hard_mute = 1'b1;
    cyc();
    hard_mute = 1'b0;
    check("mute gain", 128'(g_of(ga, 2)), 128'(0));
    check("mute off", 128'(off_a), 128'(1));
    run_ticks(1);
    check("mute re-ramp", 128'(g_of(ga, 2)), 128'(4));

    // Large step clamps on both ends.
    ch_enable = '0;
    run_ticks(256);
    ch_enable = 12'h001;
    run_ticks(1);
    check("b up 1", 128'(g_of(gb, 0)), 128'(1000));
    run_ticks(1);
    check("b up clamp", 128'(g_of(gb, 0)), 128'(1023));
    ch_enable = '0;
    run_ticks(1);
    check("b down 1", 128'(g_of(gb, 0)), 128'(23));
    run_ticks(1);
    check("b down clamp", 128'(g_of(gb, 0)), 128'(0));

    // Async reset mid-ramp.
    ch_enable = 12'hfff;
    run_ticks(50);
    async_reset("mid");
    run_ticks(10);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) ch_enable = NCH'($urandom);
      if ($urandom_range(0, 40) == 0) master_enable = ~master_enable;
      hard_mute = ($urandom_range(0, 60) == 0);
      if (n == 1500) async_reset("rand");
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
